// File: rtl/queue_wr_arbiter_pkg.sv
// Shared definitions for the queue write arbiter: FSM encoding, default queue geometry
// and a small index-wrap helper for the rotating-priority search.
package queue_wr_arbiter_pkg;

    localparam int QARB_QUEUE_SIZE     = 8;
    localparam int QARB_QUEUE_SIZE_BIT = 3;

    typedef enum logic {
        QARB_ISSUE   = 1'b0,
        QARB_BLOCKED = 1'b1
    } qarb_state_e;

    // Operands are always below 2*n here, so one conditional subtract suffices.
    function automatic int qarb_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/queue_wr_arbiter_rr_arbiter.sv
// Purely combinational rotating-priority pick: the first set request at or after
// i_ptr (ascending, wrapping) wins.
module queue_wr_arbiter_rr_arbiter
    import queue_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        // Scan farthest-first so the nearest candidate overwrites earlier hits.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = ID_W'(qarb_wrap(int'(i_ptr) + k, NUM_REQ));
            if (i_req[w_cand]) begin
                o_grant         = '0;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                o_any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/queue_wr_arbiter.sv
// Round-robin write-side arbiter sharing one queue between NUM_REQ requesters, with
// credit-based flow control. Optional macro QARB_STALL_CNT_EN adds the stall_cnt output.
module queue_wr_arbiter
    import queue_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int REQ_ID_WIDTH   = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int QUEUE_SIZE     = QARB_QUEUE_SIZE,
    parameter int QUEUE_SIZE_BIT = QARB_QUEUE_SIZE_BIT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          q_full,
    input  logic                          q_rd_en,
    output logic                          q_wr_en,
    output logic [DATA_WIDTH-1:0]         q_buf_in,
    output logic [REQ_ID_WIDTH-1:0]       q_grant_id,
    output logic [QUEUE_SIZE_BIT:0]       credits,
`ifdef QARB_STALL_CNT_EN
    output logic [15:0]                   stall_cnt,
`endif
    output logic                          o_fsm_state
);

    localparam int CW = QUEUE_SIZE_BIT + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(QUEUE_SIZE);

    logic                    r_wr_en;
    logic [DATA_WIDTH-1:0]   r_buf_in;
    logic [REQ_ID_WIDTH-1:0] r_grant_id;
    logic [CW-1:0]           r_credits;
    logic [REQ_ID_WIDTH-1:0] r_rr_ptr;
    qarb_state_e             r_state;

    logic [NUM_REQ-1:0]      w_grant_oh;
    logic [REQ_ID_WIDTH-1:0] w_win;
    logic                    w_any;
    logic                    w_can_grant;
    logic                    w_accept;
    logic                    w_pop;
    logic [CW-1:0]           w_credits_nxt;
    logic [REQ_ID_WIDTH-1:0] w_ptr_nxt;
    logic [DATA_WIDTH-1:0]   w_win_data;
    qarb_state_e             w_state_nxt;

    queue_wr_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (REQ_ID_WIDTH)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

    // Handshake: requester i transfers on a cycle where req_valid[i] & req_ready[i];
    // req_ready is combinational and one-hot to the round-robin winner, or all zero.
    assign w_can_grant = rst & (r_credits != '0) & ~q_full;
    assign req_ready   = w_can_grant ? w_grant_oh : '0;
    assign w_accept    = w_any & w_can_grant;
    assign w_pop       = q_rd_en & (r_credits < CRED_MAX);
    assign w_ptr_nxt   = (w_win == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == REQ_ID_WIDTH'(i)) w_win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_credits_nxt = r_credits;
        if (w_accept && !w_pop)      w_credits_nxt = r_credits - 1'b1;
        else if (w_pop && !w_accept) w_credits_nxt = r_credits + 1'b1;
    end

    always_comb begin
        w_state_nxt = QARB_ISSUE;
        if (w_credits_nxt == '0 || q_full) w_state_nxt = QARB_BLOCKED;
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= QARB_ISSUE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_en    <= 1'b0;
            r_buf_in   <= '0;
            r_grant_id <= '0;
            r_credits  <= CRED_MAX;
            r_rr_ptr   <= '0;
        end else begin
            r_wr_en   <= w_accept;
            r_credits <= w_credits_nxt;
            if (w_accept) begin
                r_buf_in   <= w_win_data;
                r_grant_id <= w_win;
                r_rr_ptr   <= w_ptr_nxt;
            end
        end
    end

`ifdef QARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) r_stall_cnt <= '0;
        else if (r_state == QARB_BLOCKED && |req_valid && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign q_wr_en     = r_wr_en;
    assign q_buf_in    = r_buf_in;
    assign q_grant_id  = r_grant_id;
    assign credits     = r_credits;
    assign o_fsm_state = r_state;

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Self-checking bench for queue_wr_arbiter: directed test-plan scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_queue_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int QS = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           q_full;
    logic           q_rd_en;
    logic           q_wr_en;
    logic [W-1:0]   q_buf_in;
    logic [1:0]     q_grant_id;
    logic [3:0]     credits;
    logic           o_fsm_state;
`ifdef QARB_STALL_CNT_EN
    logic [15:0]    stall_cnt;
`endif

    queue_wr_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .q_full      (q_full),
        .q_rd_en     (q_rd_en),
        .q_wr_en     (q_wr_en),
        .q_buf_in    (q_buf_in),
        .q_grant_id  (q_grant_id),
        .credits     (credits),
`ifdef QARB_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .o_fsm_state (o_fsm_state)
    );

    always #5 clk = ~clk;

    logic [W-1:0] d [N];
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: registered outputs as the rules say they must look after each edge.
    int           m_cred = QS;
    int           m_ptr  = 0;
    int           m_id   = 0;
    int           m_w    = -1;
    int           m_stall = 0;
    logic         m_wr   = 1'b0;
    logic         m_acc  = 1'b0;
    logic         m_state = 1'b0;
    logic [W-1:0] m_buf  = '0;
    logic [N-1:0] last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge; check req_ready before the edge and registered outputs after.
    task automatic step(input logic [N-1:0] v, input logic full, input logic rd, input logic rstn);
        logic [N-1:0] exp_ready;
        int idx;
        logic can;
        req_valid = v;
        q_full    = full;
        q_rd_en   = rd;
        rst       = rstn;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = d[i];
        #1;
        m_w = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (m_w < 0 && v[idx[1:0]]) m_w = idx;
        end
        can       = rstn && (m_cred != 0) && !full;
        m_acc     = can && (m_w >= 0);
        exp_ready = m_acc ? (N'(1) << m_w) : '0;
        chk("req_ready", req_ready, exp_ready);
        last_ready = req_ready;
        @(posedge clk);
        if (!rstn) begin
            m_wr = 1'b0; m_buf = '0; m_id = 0; m_cred = QS; m_ptr = 0; m_state = 1'b0;
            m_stall = 0;
            exp_q.delete();
        end else begin
            if (m_state && (v != '0) && m_stall < 65535) m_stall++;
            m_wr = m_acc;
            if (m_acc) begin
                m_buf = d[m_w];
                m_id  = m_w;
                m_ptr = (m_w + 1) % N;
                exp_q.push_back(d[m_w]);
            end
            m_cred  = m_cred - (m_acc ? 1 : 0) + ((rd && m_cred < QS) ? 1 : 0);
            m_state = (m_cred == 0) || full;
        end
        @(negedge clk);
        chk("q_wr_en", q_wr_en, m_wr);
        if (q_wr_en === 1'b1) begin
            if (exp_q.size() == 0) chk("write_unexpected", 1, 0);
            else chk("write_data", q_buf_in, exp_q.pop_front());
        end
        if (exp_q.size() != 0) begin
            chk("write_missing", exp_q.size(), 0);
            exp_q.delete();
        end
        chk("q_buf_in", q_buf_in, m_buf);
        chk("q_grant_id", q_grant_id, m_id);
        chk("credits", credits, m_cred);
        chk("fsm_state", o_fsm_state, m_state);
`ifdef QARB_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    logic [N-1:0] pend;
    logic [N-1:0] rv;

    initial begin
        rst = 1'b0; req_valid = '0; req_data = '0; q_full = 1'b0; q_rd_en = 1'b0;
        for (int i = 0; i < N; i++) d[i] = '0;
        @(negedge clk);

        step('0, 0, 0, 0);
        step('0, 0, 0, 0);
        chk("rst_credits", credits, 8);
        chk("rst_wr_en", q_wr_en, 0);

        d[0] = 10;
        step(4'b0001, 0, 0, 1);
        chk("t1_wr", q_wr_en, 1);
        chk("t1_data", q_buf_in, 10);
        chk("t1_id", q_grant_id, 0);
        chk("t1_credits", credits, 7);
        step('0, 0, 0, 1);
        chk("t1_pulse", q_wr_en, 0);

        step('0, 0, 0, 0);
        d = '{10, 20, 30, 40};
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 0, 0, 1);
            chk("rr_data", q_buf_in, 10 * ((k % 4) + 1));
            chk("rr_id", q_grant_id, k % 4);
            chk("rr_credits", credits, 7 - k);
        end
        chk("full_state", o_fsm_state, 1);
        step(4'b1111, 0, 0, 1);
        chk("blocked_ready", last_ready, 0);
        chk("blocked_wr", q_wr_en, 0);
        d[0] = 90;
        step(4'b1111, 0, 1, 1);
        chk("pop_credits", credits, 1);
        chk("pop_wr", q_wr_en, 0);
        chk("pop_state", o_fsm_state, 0);
        step(4'b1111, 0, 0, 1);
        chk("ninth_data", q_buf_in, 90);
        chk("ninth_credits", credits, 0);

        step('0, 0, 0, 0);
        d[0] = 5;
        repeat (5) step(4'b0001, 0, 0, 1);
        chk("c3_credits", credits, 3);
        step(4'b0001, 0, 1, 1);
        chk("acc_pop_credits", credits, 3);
        chk("acc_pop_wr", q_wr_en, 1);
        step('0, 0, 0, 0);
        step('0, 0, 1, 1);
        chk("empty_pop_credits", credits, 8);

        step('0, 0, 0, 0);
        repeat (3) step(4'b0001, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1, 0, 1);
            chk("qfull_wr", q_wr_en, 0);
            chk("qfull_credits", credits, 5);
            chk("qfull_state", o_fsm_state, 1);
        end
        step(4'b1111, 0, 0, 1);
        chk("qfull_resume_wr", q_wr_en, 1);
        chk("qfull_resume_credits", credits, 4);

        step('0, 0, 0, 0);
        step(4'b1111, 0, 0, 1);
        step(4'b1111, 0, 0, 0);
        chk("midrst_wr", q_wr_en, 0);
        chk("midrst_credits", credits, 8);
        step(4'b1111, 0, 0, 1);
        chk("midrst_ptr", q_grant_id, 0);

        pend = '0;
        repeat (3000) begin
            rv = pend;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    d[i]  = $urandom;
                end
            end
            pend = rv;
            step(rv, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 299) != 0));
            if (m_acc) pend = pend & ~(N'(1) << m_w);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
